rob_commit_writer: RTL and testbench
====================================

Name: rob_commit_writer

Overview:
- In-order retirement unit for the out-of-order core, and the write-side producer for the architectural register file.
- Allocates reorder-buffer entries at dispatch and captures results from the common data bus (CDB) in any order.
- Retires at most one entry per cycle in program order, driving the register file's write port (regWrite, wraddress, wdata, validCommit).

Parameters:
- D_WIDTH, 31, MSB index of the data word (data is D_WIDTH+1 bits).
- A_WIDTH, 4, MSB index of a register address (address is A_WIDTH+1 bits).
- TAG_W, 3, width of a ROB tag.
- ROB_DEPTH, 8, number of entries; must equal 2^TAG_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- alloc_valid  in  1  dispatch requests a new entry this cycle.
- alloc_rd  in  A_WIDTH+1  destination register of the dispatched instruction.
- alloc_has_dest  in  1  instruction writes a register.
- alloc_ready  out  1  ROB not full; combinational from count.
- alloc_tag  out  TAG_W  tag granted to this cycle's allocation (the tail pointer).
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_W  tag of the completing entry.
- cdb_data  in  D_WIDTH+1  result value.
- flush  in  1  synchronous squash of all entries.
- regWrite  out  1  register-file write enable.
- wraddress  out  A_WIDTH+1  register-file write address.
- wdata  out  D_WIDTH+1  register-file write data.
- validCommit  out  1  one instruction retired this cycle.
- count  out  TAG_W+1  number of occupied entries (0..ROB_DEPTH).

Behaviour:
- Storage:
  - Per-entry fields: valid, done, has_dest, rd, data.
  - head and tail pointers, each TAG_W bits, wrapping modulo ROB_DEPTH.
  - count register.
- Reset (asynchronous): all entries invalid; head, tail and count = 0. regWrite = 0, validCommit = 0, wraddress = 0, wdata = 0. alloc_ready = 1, alloc_tag = 0.
- Allocation:
  - Accepted when alloc_valid && alloc_ready.
  - Entry[tail] gets valid=1, done=0, has_dest and rd from the alloc inputs; tail advances by 1.
  - alloc_ready = (count < ROB_DEPTH), based on the current count only. When full, an allocation is refused even if a commit happens in the same cycle.
  - alloc_valid while not ready: ignored, no state change.
- CDB capture:
  - When cdb_valid and entry[cdb_tag].valid: set done=1 and store cdb_data.
  - When entry[cdb_tag] is not valid, the CDB write is ignored entirely.
- Commit:
  - Fires when entry[head].valid && entry[head].done at a clock edge.
  - Outputs registered at that edge: validCommit=1; regWrite = has_dest && (rd != 0); wraddress = rd; wdata = data.
  - Entry[head].valid is cleared and head advances by 1.
  - When no commit fires: validCommit=0 and regWrite=0; wraddress and wdata hold their last values.
- Latency: a CDB result captured at edge k for the head entry produces regWrite/validCommit high after edge k+1. Outputs are never combinational from the CDB.
- Commit rate: at most one per cycle. Consecutive done entries retire on consecutive cycles with no bubbles.
- Count update: +1 on allocation, −1 on commit; both in the same cycle leaves count unchanged.
- Flush:
  - Highest priority; overrides allocation, CDB capture and commit in that cycle.
  - Clears all valid bits; head = tail = count = 0.
  - regWrite = 0 and validCommit = 0 after that edge.
- Reset asserted mid-operation: all state cleared immediately, with no clock edge required. The pending commit is lost.
- Wrap-around: pointers roll from ROB_DEPTH−1 to 0. Tags are reused only after the previous occupant has retired.

Test Plan:
- In-order retire of out-of-order results: allocate rd=4, 9, 3 (tags 0, 1, 2); CDB tag2=60, tag1=80, tag0=60 on successive cycles -> three consecutive cycles with regWrite=1 and (wraddress, wdata) = (4,60), (9,80), (3,60); count returns to 0.
- No-destination and x0 writes: allocate with has_dest=0 and with rd=0, then complete both -> validCommit=1 on each commit cycle, regWrite=0 on both.
- Full and wrap: allocate 8 entries -> alloc_ready=0, count=8, and a 9th alloc_valid is ignored. Complete tag0 -> commit, alloc_ready=1, next allocation receives alloc_tag=0.
- Stale CDB: cdb_valid with tag 5 while only tags 0–1 are allocated -> no state change and no commit; entry 5 later allocated still shows done=0.
- Flush: 3 entries pending, one done, flush=1 in the same cycle as a CDB hit on the head -> count=0, no commit that cycle or after; the next allocation gets alloc_tag=0.
- Reset mid-operation: assert reset between clock edges while a commit is pending -> regWrite, validCommit and count drop to 0 immediately; after release, alloc_ready=1 and alloc_tag=0.

Source files
------------

// File: rtl/rob_commit_writer.sv
// Reorder buffer with in-order retirement onto the architectural register
// file write port. Entries are allocated at dispatch, completed from the
// CDB in any order, and retired one per cycle from the head.
module rob_commit_writer #(
   parameter int D_WIDTH   = 31,
   parameter int A_WIDTH   = 4,
   parameter int TAG_W     = 3,
   parameter int ROB_DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               alloc_valid,
   input  logic [A_WIDTH:0]   alloc_rd,
   input  logic               alloc_has_dest,
   output logic               alloc_ready,
   output logic [TAG_W-1:0]   alloc_tag,
   input  logic               cdb_valid,
   input  logic [TAG_W-1:0]   cdb_tag,
   input  logic [D_WIDTH:0]   cdb_data,
   input  logic               flush,
   output logic               regWrite,
   output logic [A_WIDTH:0]   wraddress,
   output logic [D_WIDTH:0]   wdata,
   output logic               validCommit,
   output logic [TAG_W:0]     count
);

   localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
   localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
   localparam logic [TAG_W:0]   DEPTH_C  = (TAG_W+1)'(ROB_DEPTH);

   // Per-entry storage
   logic               valid_q    [ROB_DEPTH];
   logic               valid_d    [ROB_DEPTH];
   logic               done_q     [ROB_DEPTH];
   logic               done_d     [ROB_DEPTH];
   logic               has_dest_q [ROB_DEPTH];
   logic               has_dest_d [ROB_DEPTH];
   logic [A_WIDTH:0]   rd_q       [ROB_DEPTH];
   logic [A_WIDTH:0]   rd_d       [ROB_DEPTH];
   logic [D_WIDTH:0]   data_q     [ROB_DEPTH];
   logic [D_WIDTH:0]   data_d     [ROB_DEPTH];

   // Pointers, occupancy and registered commit port
   logic [TAG_W-1:0]   head_q, head_d;
   logic [TAG_W-1:0]   tail_q, tail_d;
   logic [TAG_W:0]     count_q, count_d;
   logic               reg_write_q, reg_write_d;
   logic               valid_commit_q, valid_commit_d;
   logic [A_WIDTH:0]   wraddress_q, wraddress_d;
   logic [D_WIDTH:0]   wdata_q, wdata_d;

   logic               alloc_fire;
   logic               commit_fire;

   // Handshake and output ports driven straight from state
   always_comb begin
      alloc_ready = (count_q < DEPTH_C);
      alloc_tag   = tail_q;
      regWrite    = reg_write_q;
      wraddress   = wraddress_q;
      wdata       = wdata_q;
      validCommit = valid_commit_q;
      count       = count_q;
   end

   // Next-state: flush wins; otherwise commit, CDB capture and allocation.
   // Commit clears the head before allocation may reuse a slot, and a CDB
   // hit on a slot being allocated this cycle is ignored because that slot
   // is not yet valid.
   always_comb begin
      valid_d        = valid_q;
      done_d         = done_q;
      has_dest_d     = has_dest_q;
      rd_d           = rd_q;
      data_d         = data_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      reg_write_d    = 1'b0;
      valid_commit_d = 1'b0;
      wraddress_d    = wraddress_q;
      wdata_d        = wdata_q;

      alloc_fire  = alloc_valid && (count_q < DEPTH_C);
      commit_fire = valid_q[head_q] && done_q[head_q];

      if (flush) begin
         valid_d = '{default: 1'b0};
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (commit_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + TAG_ONE;
            valid_commit_d  = 1'b1;
            reg_write_d     = has_dest_q[head_q] && (rd_q[head_q] != '0);
            wraddress_d     = rd_q[head_q];
            wdata_d         = data_q[head_q];
         end

         if (cdb_valid && valid_q[cdb_tag]) begin
            done_d[cdb_tag] = 1'b1;
            data_d[cdb_tag] = cdb_data;
         end

         if (alloc_fire) begin
            valid_d[tail_q]    = 1'b1;
            done_d[tail_q]     = 1'b0;
            has_dest_d[tail_q] = alloc_has_dest;
            rd_d[tail_q]       = alloc_rd;
            tail_d             = tail_q + TAG_ONE;
         end

         case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // State register with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q        <= '{default: 1'b0};
         done_q         <= '{default: 1'b0};
         has_dest_q     <= '{default: 1'b0};
         rd_q           <= '{default: '0};
         data_q         <= '{default: '0};
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         reg_write_q    <= 1'b0;
         valid_commit_q <= 1'b0;
         wraddress_q    <= '0;
         wdata_q        <= '0;
      end else begin
         valid_q        <= valid_d;
         done_q         <= done_d;
         has_dest_q     <= has_dest_d;
         rd_q           <= rd_d;
         data_q         <= data_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         reg_write_q    <= reg_write_d;
         valid_commit_q <= valid_commit_d;
         wraddress_q    <= wraddress_d;
         wdata_q        <= wdata_d;
      end
   end

endmodule

// File: tb/tb_rob_commit_writer.sv
// Directed bench for rob_commit_writer: in-order retire, no-dest/x0 writes,
// stale CDB, full/wrap, flush and asynchronous reset.
module tb_rob_commit_writer;

   logic        clk;
   logic        reset;
   logic        alloc_valid;
   logic [4:0]  alloc_rd;
   logic        alloc_has_dest;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        flush;
   logic        regWrite;
   logic [4:0]  wraddress;
   logic [31:0] wdata;
   logic        validCommit;
   logic [3:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   rob_commit_writer #(
      .D_WIDTH(31), .A_WIDTH(4), .TAG_W(3), .ROB_DEPTH(8)
   ) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .alloc_has_dest(alloc_has_dest), .alloc_ready(alloc_ready),
      .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .flush(flush),
      .regWrite(regWrite), .wraddress(wraddress), .wdata(wdata),
      .validCommit(validCommit), .count(count)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input logic [4:0] rd, input logic hd);
      alloc_valid = 1'b1; alloc_rd = rd; alloc_has_dest = hd;
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      alloc_valid = 0; alloc_rd = 0; alloc_has_dest = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0;
      tick(); tick();
      reset = 1'b0;
      tick();
      n_checks++;
      if ({validCommit, regWrite, wraddress, wdata} !== 39'd0) begin
         n_fail++;
         $display("FAIL reset_commit_port got %h exp 0", {validCommit, regWrite, wraddress, wdata});
      end
      n_checks++;
      if ({alloc_ready, alloc_tag, count} !== {1'b1, 3'd0, 4'd0}) begin
         n_fail++;
         $display("FAIL reset_alloc got ready=%0b tag=%0d count=%0d exp 1/0/0", alloc_ready, alloc_tag, count);
      end
   endtask

   task automatic test_in_order();
      logic [38:0] exp_v [3];
      exp_v[0] = {1'b1, 1'b1, 5'd4, 32'd60};
      exp_v[1] = {1'b1, 1'b1, 5'd9, 32'd80};
      exp_v[2] = {1'b1, 1'b1, 5'd3, 32'd60};
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1'b1; alloc_has_dest = 1'b1;
         alloc_rd = (i == 0) ? 5'd4 : (i == 1) ? 5'd9 : 5'd3;
         #1;
         n_checks++;
         if (alloc_tag !== 3'(i)) begin
            n_fail++;
            $display("FAIL inorder_alloc_tag%0d got %0d exp %0d", i, alloc_tag, i);
         end
         tick();
      end
      alloc_valid = 1'b0;
      n_checks++;
      if (count !== 4'd3) begin
         n_fail++; $display("FAIL inorder_count3 got %0d exp 3", count);
      end
      for (int i = 0; i < 3; i++) begin
         cdb_valid = 1'b1;
         cdb_tag   = 3'(2 - i);
         cdb_data  = (i == 1) ? 32'd80 : 32'd60;
         tick();
         n_checks++;
         if (validCommit !== 1'b0) begin
            n_fail++; $display("FAIL inorder_no_early_commit%0d got %0b exp 0", i, validCommit);
         end
      end
      cdb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({validCommit, regWrite, wraddress, wdata} !== exp_v[i]) begin
            n_fail++;
            $display("FAIL inorder_commit%0d got %h exp %h", i, {validCommit, regWrite, wraddress, wdata}, exp_v[i]);
         end
      end
      n_checks++;
      if (count !== 4'd0) begin
         n_fail++; $display("FAIL inorder_count0 got %0d exp 0", count);
      end
      tick();
      n_checks++;
      if ({validCommit, regWrite, wraddress, wdata} !== {1'b0, 1'b0, 5'd3, 32'd60}) begin
         n_fail++;
         $display("FAIL inorder_idle_hold got %h exp %h", {validCommit, regWrite, wraddress, wdata}, {1'b0, 1'b0, 5'd3, 32'd60});
      end
   endtask

   // Continues from head = tail = 3
   task automatic test_no_dest();
      do_alloc(5'd7, 1'b0);
      do_alloc(5'd0, 1'b1);
      cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'd11;
      tick();
      n_checks++;
      if (validCommit !== 1'b0) begin
         n_fail++; $display("FAIL nodest_capture got vc=%0b exp 0", validCommit);
      end
      cdb_tag = 3'd4; cdb_data = 32'd22;
      tick();
      n_checks++;
      if ({validCommit, regWrite, wraddress, wdata} !== {1'b1, 1'b0, 5'd7, 32'd11}) begin
         n_fail++;
         $display("FAIL nodest_commit got %h exp %h", {validCommit, regWrite, wraddress, wdata}, {1'b1, 1'b0, 5'd7, 32'd11});
      end
      cdb_valid = 1'b0;
      tick();
      n_checks++;
      if ({validCommit, regWrite, wraddress, wdata} !== {1'b1, 1'b0, 5'd0, 32'd22}) begin
         n_fail++;
         $display("FAIL x0_commit got %h exp %h", {validCommit, regWrite, wraddress, wdata}, {1'b1, 1'b0, 5'd0, 32'd22});
      end
   endtask

   task automatic test_stale_cdb();
      logic [4:0] rd_exp;
      do_flush();
      do_alloc(5'd1, 1'b1);
      do_alloc(5'd2, 1'b1);
      cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 32'd99;
      tick();
      cdb_valid = 1'b0;
      n_checks++;
      if ({validCommit, count} !== {1'b0, 4'd2}) begin
         n_fail++; $display("FAIL stale_no_change got vc=%0b count=%0d exp 0/2", validCommit, count);
      end
      for (int t = 2; t < 6; t++) do_alloc(5'(t + 3), 1'b1);
      for (int i = 0; i < 5; i++) begin
         cdb_valid = 1'b1; cdb_tag = 3'(i); cdb_data = 32'(100 + i);
         tick();
         if (i > 0) begin
            rd_exp = (i - 1 < 2) ? 5'(i) : 5'(i + 2);
            n_checks++;
            if ({validCommit, regWrite, wraddress, wdata} !== {1'b1, 1'b1, rd_exp, 32'(99 + i)}) begin
               n_fail++;
               $display("FAIL stale_commit_tag%0d got %h exp %h", i - 1, {validCommit, regWrite, wraddress, wdata}, {1'b1, 1'b1, rd_exp, 32'(99 + i)});
            end
         end
      end
      cdb_valid = 1'b0;
      tick();
      n_checks++;
      if ({validCommit, regWrite, wraddress, wdata} !== {1'b1, 1'b1, 5'd7, 32'd104}) begin
         n_fail++;
         $display("FAIL stale_commit_tag4 got %h exp %h", {validCommit, regWrite, wraddress, wdata}, {1'b1, 1'b1, 5'd7, 32'd104});
      end
      tick();
      n_checks++;
      if ({validCommit, count} !== {1'b0, 4'd1}) begin
         n_fail++; $display("FAIL stale_tag5_not_done got vc=%0b count=%0d exp 0/1", validCommit, count);
      end
      cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 32'd77;
      tick();
      cdb_valid = 1'b0;
      tick();
      n_checks++;
      if ({validCommit, regWrite, wraddress, wdata, count} !== {1'b1, 1'b1, 5'd8, 32'd77, 4'd0}) begin
         n_fail++;
         $display("FAIL stale_tag5_commit got %h exp %h", {validCommit, regWrite, wraddress, wdata, count}, {1'b1, 1'b1, 5'd8, 32'd77, 4'd0});
      end
   endtask

   task automatic test_full_wrap();
      do_flush();
      for (int i = 0; i < 8; i++) do_alloc(5'(i + 1), 1'b1);
      n_checks++;
      if ({alloc_ready, alloc_tag, count} !== {1'b0, 3'd0, 4'd8}) begin
         n_fail++; $display("FAIL full_state got ready=%0b tag=%0d count=%0d exp 0/0/8", alloc_ready, alloc_tag, count);
      end
      do_alloc(5'd31, 1'b1);
      n_checks++;
      if ({alloc_tag, count} !== {3'd0, 4'd8}) begin
         n_fail++; $display("FAIL full_ninth_ignored got tag=%0d count=%0d exp 0/8", alloc_tag, count);
      end
      cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'd55;
      tick();
      cdb_valid = 1'b0;
      tick();
      n_checks++;
      if ({validCommit, regWrite, wraddress, wdata} !== {1'b1, 1'b1, 5'd1, 32'd55}) begin
         n_fail++;
         $display("FAIL full_commit_tag0 got %h exp %h", {validCommit, regWrite, wraddress, wdata}, {1'b1, 1'b1, 5'd1, 32'd55});
      end
      n_checks++;
      if ({alloc_ready, alloc_tag, count} !== {1'b1, 3'd0, 4'd7}) begin
         n_fail++; $display("FAIL wrap_ready got ready=%0b tag=%0d count=%0d exp 1/0/7", alloc_ready, alloc_tag, count);
      end
      do_alloc(5'd20, 1'b1);
      n_checks++;
      if ({alloc_ready, alloc_tag, count} !== {1'b0, 3'd1, 4'd8}) begin
         n_fail++; $display("FAIL wrap_alloc got ready=%0b tag=%0d count=%0d exp 0/1/8", alloc_ready, alloc_tag, count);
      end
      cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'd66;
      tick();
      cdb_valid = 1'b0;
      alloc_valid = 1'b1; alloc_rd = 5'd21; alloc_has_dest = 1'b1;
      tick();
      alloc_valid = 1'b0;
      n_checks++;
      if ({validCommit, regWrite, wraddress, wdata, alloc_tag, count} !== {1'b1, 1'b1, 5'd2, 32'd66, 3'd1, 4'd7}) begin
         n_fail++;
         $display("FAIL full_refuse_with_commit got %h exp %h", {validCommit, regWrite, wraddress, wdata, alloc_tag, count}, {1'b1, 1'b1, 5'd2, 32'd66, 3'd1, 4'd7});
      end
   endtask

   task automatic test_flush();
      do_flush();
      do_alloc(5'd10, 1'b1);
      do_alloc(5'd11, 1'b1);
      do_alloc(5'd12, 1'b1);
      cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'd5;
      tick();
      cdb_tag = 3'd0; cdb_data = 32'd6; flush = 1'b1;
      tick();
      flush = 1'b0; cdb_valid = 1'b0;
      n_checks++;
      if ({validCommit, regWrite, count} !== {1'b0, 1'b0, 4'd0}) begin
         n_fail++; $display("FAIL flush_edge got vc=%0b rw=%0b count=%0d exp 0/0/0", validCommit, regWrite, count);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if ({validCommit, regWrite} !== 2'b00) begin
            n_fail++; $display("FAIL flush_no_commit%0d got vc=%0b rw=%0b exp 0/0", i, validCommit, regWrite);
         end
      end
      n_checks++;
      if ({alloc_ready, alloc_tag} !== {1'b1, 3'd0}) begin
         n_fail++; $display("FAIL flush_alloc_tag got ready=%0b tag=%0d exp 1/0", alloc_ready, alloc_tag);
      end
   endtask

   task automatic test_reset_mid();
      do_flush();
      do_alloc(5'd9, 1'b1);
      do_alloc(5'd14, 1'b1);
      cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'd33;
      tick();
      cdb_tag = 3'd1; cdb_data = 32'd44;
      tick();
      cdb_valid = 1'b0;
      n_checks++;
      if ({validCommit, regWrite, wraddress, wdata, count} !== {1'b1, 1'b1, 5'd9, 32'd33, 4'd1}) begin
         n_fail++;
         $display("FAIL rstmid_pre got %h exp %h", {validCommit, regWrite, wraddress, wdata, count}, {1'b1, 1'b1, 5'd9, 32'd33, 4'd1});
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({validCommit, regWrite, wraddress, wdata, count} !== 43'd0) begin
         n_fail++;
         $display("FAIL rstmid_async got %h exp 0", {validCommit, regWrite, wraddress, wdata, count});
      end
      tick();
      reset = 1'b0;
      tick();
      n_checks++;
      if ({validCommit, regWrite, alloc_ready, alloc_tag, count} !== {1'b0, 1'b0, 1'b1, 3'd0, 4'd0}) begin
         n_fail++;
         $display("FAIL rstmid_after got vc=%0b rw=%0b ready=%0b tag=%0d count=%0d exp 0/0/1/0/0", validCommit, regWrite, alloc_ready, alloc_tag, count);
      end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_no_dest();
      test_stale_cdb();
      test_full_wrap();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
